// File: rtl/slurm16_ifetch_responder_if.sv
// Instruction-fetch responder bus bundle.
// Groups the CPU fetch port, the flush strobe, the memory-arbiter read port and
// the protocol error flag.
// Modports:
//   slave  - the responder: takes the CPU request and memory returns, drives accept/valid/data and mem_req
//   master - the environment: drives the CPU request, flush and the memory returns
interface slurm16_ifetch_responder_if #(
    parameter int unsigned ADDR_BITS = 15,
    parameter int unsigned DATA_BITS = 16
);
    logic                 instruction_request;
    logic [ADDR_BITS-1:0] instruction_address;
    logic                 fetch_accept;
    logic                 instruction_valid;
    logic [DATA_BITS-1:0] instruction_in;
    logic [ADDR_BITS-1:0] instruction_address_in;
    logic                 flush;
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 protocol_error;

    modport slave (
        input  instruction_request, instruction_address, flush, mem_gnt, mem_rvalid, mem_rdata,
        output fetch_accept, instruction_valid, instruction_in, instruction_address_in,
               mem_req, mem_addr, protocol_error
    );

    modport master (
        output instruction_request, instruction_address, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  fetch_accept, instruction_valid, instruction_in, instruction_address_in,
               mem_req, mem_addr, protocol_error
    );
endinterface

// File: rtl/slurm16_ifetch_responder.sv
// slurm16 instruction-fetch responder.
// Accepts CPU fetch requests, issues them to the memory arbiter, tags in-order
// returns with their address from a pending-address FIFO and drops returns
// belonging to fetches discarded by flush.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - slurm16_ifetch_responder_if.slave (CPU fetch port, flush, memory port, protocol_error)
// Optional feature: define SLURM16_IFETCH_REPEAT_CACHE_EN to add a one-entry
// {address, word} cache that serves repeated fetches while nothing is outstanding.
module slurm16_ifetch_responder #(
    parameter int unsigned ADDR_BITS = 15,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    slurm16_ifetch_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} state_t;

    state_t               r_state, w_state_next;
    logic [ADDR_BITS-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count, r_discard;
    logic [CNT_W-1:0]     w_count_next, w_discard_next;
    logic                 r_valid, r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 w_full, w_empty, w_hit, w_mem_req, w_push, w_pop, w_deliver;
    logic [ADDR_BITS-1:0] w_head_addr;
    logic [DATA_BITS-1:0] w_hit_data;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head_addr = r_fifo[r_rd_ptr];

`ifdef SLURM16_IFETCH_REPEAT_CACHE_EN
    logic                 r_cache_valid;
    logic [ADDR_BITS-1:0] r_cache_addr;
    logic [DATA_BITS-1:0] r_cache_data;

    // A hit is only allowed with nothing outstanding so delivery stays in order;
    // a flush-cycle request is sent to memory (and discarded) instead.
    assign w_hit = ~i_rst & bus.instruction_request & ~bus.flush & r_cache_valid &
                   (r_state == ST_IDLE) & (bus.instruction_address == r_cache_addr);
    assign w_hit_data = r_cache_data;

    // Remember the last word handed to the CPU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
        end else if (bus.flush) begin
            r_cache_valid <= 1'b0;
        end else if (w_deliver) begin
            r_cache_valid <= 1'b1;
            r_cache_addr  <= w_head_addr;
            r_cache_data  <= bus.mem_rdata;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // Full blocks the request even when a return frees a slot this cycle.
    assign w_mem_req = ~i_rst & bus.instruction_request & ~w_full & ~w_hit;
    assign w_push    = w_mem_req & bus.mem_gnt;
    assign w_pop     = bus.mem_rvalid & ~w_empty;
    // A return coinciding with flush belongs to a discarded fetch.
    assign w_deliver = w_pop & (r_discard == '0) & ~bus.flush;

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign bus.mem_req                = w_mem_req;
    assign bus.mem_addr               = bus.instruction_address;
    assign bus.fetch_accept           = w_push | w_hit;
    assign bus.instruction_valid      = r_valid;
    assign bus.instruction_in         = r_data;
    assign bus.instruction_address_in = r_addr;
    assign bus.protocol_error         = r_perr;

    // Discard count and state: flush marks everything still outstanding as stale.
    always_comb begin
        w_discard_next = r_discard;
        w_state_next   = r_state;
        if (bus.flush) begin
            w_discard_next = w_count_next;
        end else if (w_pop && (r_discard != '0)) begin
            w_discard_next = r_discard - CNT_W'(1);
        end
        case (r_state)
            ST_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = (w_discard_next != '0) ? ST_DRAIN : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_IDLE;
                end else if (w_discard_next != '0) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_discard_next == '0) begin
                    w_state_next = (w_count_next == '0) ? ST_IDLE : ST_BUSY;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pending-address storage; contents are don't-care when empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.instruction_address;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_discard <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_addr    <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_discard <= w_discard_next;
            r_valid   <= w_deliver | w_hit;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_deliver) begin
                r_data <= bus.mem_rdata;
                r_addr <= w_head_addr;
            end else if (w_hit) begin
                r_data <= w_hit_data;
                r_addr <= bus.instruction_address;
            end
            if (bus.mem_rvalid && w_empty) begin
                r_perr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_slurm16_ifetch_responder.sv
// Self-checking bench for slurm16_ifetch_responder: reset, table-driven single
// fetches, burst/full, flush, repeat fetch, protocol error, then randomized
// traffic against a queue-based reference model.
module tb_slurm16_ifetch_responder;
    localparam int unsigned AB    = 15;
    localparam int unsigned DB    = 16;
    localparam int unsigned DEPTH = 4;
`ifdef SLURM16_IFETCH_REPEAT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slurm16_ifetch_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    slurm16_ifetch_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        int            lat;
    } vec_t;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic          doomed;
    } pend_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] memfun(input logic [AB-1:0] a);
        return (DB'(a) * 16'd7) ^ 16'h5A3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instruction_request = 1'b0;
        bus.instruction_address = '0;
        bus.flush               = 1'b0;
        bus.mem_gnt             = 1'b0;
        bus.mem_rvalid          = 1'b0;
        bus.mem_rdata           = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Single fetch: grant in cycle N, rvalid in N+lat, word visible in N+lat+1.
    task automatic fetch_one(input logic [AB-1:0] a, input logic [DB-1:0] d, input int lat);
        bus.instruction_request = 1'b1;
        bus.instruction_address = a;
        bus.mem_gnt             = 1'b1;
        #1;
        chk("single_accept", 32'(bus.fetch_accept), 32'd1);
        chk("single_mem_addr", 32'(bus.mem_addr), 32'(a));
        tick();
        bus.instruction_request = 1'b0;
        bus.mem_gnt             = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk("single_wait_valid", 32'(bus.instruction_valid), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        chk("single_valid", 32'(bus.instruction_valid), 32'd1);
        chk("single_data", 32'(bus.instruction_in), 32'(d));
        chk("single_addr", 32'(bus.instruction_address_in), 32'(a));
        tick();
        chk("single_valid_pulse", 32'(bus.instruction_valid), 32'd0);
    endtask

    // Reference model state
    pend_t         pend[$];
    logic          m_valid;
    logic [DB-1:0] m_data;
    logic [AB-1:0] m_addr;
    logic          m_cv;
    logic [AB-1:0] m_ca;
    logic [DB-1:0] m_cd;

    initial begin
        vec_t          tbl[4];
        logic [AB-1:0] memq[$];
        logic [AB-1:0] nxt;
        int            acc;
        int            got;

        tbl[0] = '{addr: 15'h0005, data: 16'h3013, lat: 3};
        tbl[1] = '{addr: 15'h7FFF, data: 16'hFFFF, lat: 1};
        tbl[2] = '{addr: 15'h0000, data: 16'h0000, lat: 2};
        tbl[3] = '{addr: 15'h1234, data: 16'hA5A5, lat: 5};

        // Reset with request held high
        rst = 1'b1;
        idle_inputs();
        bus.instruction_request = 1'b1;
        bus.instruction_address = 15'h0055;
        bus.mem_gnt             = 1'b1;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_accept", 32'(bus.fetch_accept), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_valid", 32'(bus.instruction_valid), 32'd0);
            chk("rst_data", 32'(bus.instruction_in), 32'd0);
            chk("rst_addr", 32'(bus.instruction_address_in), 32'd0);
            chk("rst_perr", 32'(bus.protocol_error), 32'd0);
            chk("rst_mem_req_hold", 32'(bus.mem_req), 32'd0);
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        // Table-driven single fetches with varying latency
        for (int i = 0; i < 4; i++) begin
            fetch_one(tbl[i].addr, tbl[i].data, tbl[i].lat);
        end

        // Burst: rvalid held off, exactly DEPTH accepts then mem_req drops
        nxt = 15'h0010;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.instruction_request = 1'b1;
            bus.instruction_address = nxt;
            bus.mem_gnt             = 1'b1;
            #1;
            if (bus.fetch_accept) begin
                memq.push_back(nxt);
                nxt = nxt + 15'd1;
                acc++;
            end
            tick();
        end
        chk("burst_accepts", 32'(acc), 32'(DEPTH));
        chk("burst_full_mem_req", 32'(bus.mem_req), 32'd0);
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (bus.instruction_valid) begin
                chk("burst_addr", 32'(bus.instruction_address_in), 32'(15'h0010 + AB'(got)));
                chk("burst_data", 32'(bus.instruction_in), 32'(memfun(15'h0010 + AB'(got))));
                got++;
            end
            bus.instruction_request = (nxt <= 15'h0017);
            bus.instruction_address = nxt;
            bus.mem_gnt             = 1'b1;
            bus.mem_rvalid          = (memq.size() > 0);
            bus.mem_rdata           = (memq.size() > 0) ? memfun(memq[0]) : '0;
            #1;
            if (bus.mem_rvalid) void'(memq.pop_front());
            if (bus.fetch_accept) begin
                memq.push_back(nxt);
                nxt = nxt + 15'd1;
            end
            tick();
        end
        chk("burst_words", 32'(got), 32'd8);
        idle_inputs();
        tick();

        // Flush together with the first return; only the post-flush fetch survives
        for (int i = 0; i < 3; i++) begin
            bus.instruction_request = 1'b1;
            bus.instruction_address = 15'h0020 + AB'(i);
            bus.mem_gnt             = 1'b1;
            #1;
            chk("flush_pre_accept", 32'(bus.fetch_accept), 32'd1);
            tick();
        end
        idle_inputs();
        bus.flush      = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = memfun(15'h0020);
        tick();
        bus.flush = 1'b0;
        chk("flush_drop0", 32'(bus.instruction_valid), 32'd0);
        bus.instruction_request = 1'b1;
        bus.instruction_address = 15'h0040;
        bus.mem_gnt             = 1'b1;
        bus.mem_rdata           = memfun(15'h0021);
        #1;
        chk("flush_new_accept", 32'(bus.fetch_accept), 32'd1);
        tick();
        bus.instruction_request = 1'b0;
        bus.mem_gnt             = 1'b0;
        chk("flush_drop1", 32'(bus.instruction_valid), 32'd0);
        bus.mem_rdata = memfun(15'h0022);
        tick();
        chk("flush_drop2", 32'(bus.instruction_valid), 32'd0);
        bus.mem_rdata = memfun(15'h0040);
        tick();
        bus.mem_rvalid = 1'b0;
        chk("flush_keep_valid", 32'(bus.instruction_valid), 32'd1);
        chk("flush_keep_addr", 32'(bus.instruction_address_in), 32'h0040);
        chk("flush_keep_data", 32'(bus.instruction_in), 32'(memfun(15'h0040)));
        tick();
        chk("flush_no_perr", 32'(bus.protocol_error), 32'd0);

        // Repeat fetch: served from the cache only when the cache is built in
        fetch_one(15'h0030, 16'h2112, 2);
        bus.instruction_request = 1'b1;
        bus.instruction_address = 15'h0030;
        bus.mem_gnt             = 1'b0;
        #1;
        chk("repeat_mem_req", 32'(bus.mem_req), 32'(!CACHE_EN));
        chk("repeat_accept", 32'(bus.fetch_accept), 32'(CACHE_EN));
        tick();
        bus.instruction_request = 1'b0;
        chk("repeat_valid", 32'(bus.instruction_valid), 32'(CACHE_EN));
        chk("repeat_data", 32'(bus.instruction_in), 32'h2112);
        chk("repeat_addr", 32'(bus.instruction_address_in), 32'h0030);
        bus.flush = 1'b1;
        tick();
        bus.flush               = 1'b0;
        bus.instruction_request = 1'b1;
        #1;
        chk("repeat_after_flush_mem_req", 32'(bus.mem_req), 32'd1);
        chk("repeat_after_flush_accept", 32'(bus.fetch_accept), 32'd0);
        tick();
        idle_inputs();

        // Stray return with nothing outstanding
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hDEAD;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("perr_set", 32'(bus.protocol_error), 32'd1);
        chk("perr_no_valid", 32'(bus.instruction_valid), 32'd0);
        repeat (3) tick();
        chk("perr_sticky", 32'(bus.protocol_error), 32'd1);
        do_reset(1);
        chk("perr_cleared", 32'(bus.protocol_error), 32'd0);

        // Randomized traffic against the reference model
        do_reset(2);
        pend.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_addr  = '0;
        m_cv    = 1'b0;
        m_ca    = '0;
        m_cd    = '0;
        for (int i = 0; i < 1600; i++) begin
            logic hit, mreq, nv;
            pend_t h;
            chk("rnd_valid", 32'(bus.instruction_valid), 32'(m_valid));
            chk("rnd_data", 32'(bus.instruction_in), 32'(m_data));
            chk("rnd_addr", 32'(bus.instruction_address_in), 32'(m_addr));
            if (i < 1500) begin
                bus.instruction_request = ($urandom_range(0, 9) < 7);
                bus.instruction_address = AB'($urandom_range(0, 15));
                bus.mem_gnt             = ($urandom_range(0, 9) < 7);
                bus.flush               = ($urandom_range(0, 19) == 0);
                bus.mem_rvalid          = (pend.size() > 0) && ($urandom_range(0, 9) < 6);
            end else begin
                bus.instruction_request = 1'b0;
                bus.mem_gnt             = 1'b0;
                bus.flush               = 1'b0;
                bus.mem_rvalid          = (pend.size() > 0);
            end
            bus.mem_rdata = bus.mem_rvalid ? memfun(pend[0].addr) : '0;
            #1;
            hit  = CACHE_EN && m_cv && (pend.size() == 0) && bus.instruction_request &&
                   (bus.instruction_address == m_ca) && !bus.flush;
            mreq = bus.instruction_request && (pend.size() < DEPTH) && !hit;
            chk("rnd_mem_req", 32'(bus.mem_req), 32'(mreq));
            chk("rnd_accept", 32'(bus.fetch_accept), 32'((mreq && bus.mem_gnt) || hit));
            chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(bus.instruction_address));
            nv = 1'b0;
            if (bus.mem_rvalid && pend.size() > 0) begin
                h = pend.pop_front();
                if (!h.doomed && !bus.flush) begin
                    nv     = 1'b1;
                    m_data = memfun(h.addr);
                    m_addr = h.addr;
                    m_cv   = 1'b1;
                    m_ca   = h.addr;
                    m_cd   = m_data;
                end
            end
            if (hit) begin
                nv     = 1'b1;
                m_data = m_cd;
                m_addr = bus.instruction_address;
            end
            if (mreq && bus.mem_gnt) pend.push_back('{addr: bus.instruction_address, doomed: 1'b0});
            if (bus.flush) begin
                for (int k = 0; k < pend.size(); k++) pend[k].doomed = 1'b1;
                m_cv = 1'b0;
            end
            m_valid = nv;
            tick();
        end
        chk("rnd_final_valid", 32'(bus.instruction_valid), 32'(m_valid));
        chk("rnd_no_perr", 32'(bus.protocol_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
